// File: rtl/clock_enable_divider.sv
// Multi-channel programmable clock divider with rise/fall enable strobes and a
// frame sync strobe. Ratios may be reprogrammed at run time; changes land at a wrap.
module clock_enable_divider #(
    parameter int                            NUM_CH       = 3,
    parameter int                            CNT_WIDTH    = 8,
    parameter logic [NUM_CH*CNT_WIDTH-1:0]   DEFAULT_DIVS = {8'd2, 8'd4, 8'd12}
) (
    input  logic                                         i_clk,
    input  logic                                         i_reset_n,
    input  logic                                         i_run,
    input  logic                                         i_resync,
    input  logic                                         i_cfg_we,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] i_cfg_ch,
    input  logic [CNT_WIDTH-1:0]                         i_cfg_div,
    output logic [NUM_CH-1:0]                            o_cfg_pending,
    output logic [NUM_CH-1:0]                            o_clk,
    output logic [NUM_CH-1:0]                            o_rise_en,
    output logic [NUM_CH-1:0]                            o_fall_en,
    output logic                                         o_sync
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // Ratios below 2 cannot produce a high and a low phase.
    function automatic logic [CNT_WIDTH-1:0] clamp_div(input logic [CNT_WIDTH-1:0] v);
        clamp_div = (v < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : v;
    endfunction

    logic [CNT_WIDTH-1:0] cnt_r      [NUM_CH];
    logic [CNT_WIDTH-1:0] div_r      [NUM_CH];
    logic [CNT_WIDTH-1:0] pend_div_r [NUM_CH];
    logic [CNT_WIDTH-1:0] half_s     [NUM_CH];
    logic [NUM_CH-1:0]    pend_r;
    logic [NUM_CH-1:0]    clk_r;
    logic [NUM_CH-1:0]    rise_r;
    logic [NUM_CH-1:0]    fall_r;
    logic                 sync_r;
    logic [NUM_CH-1:0]    wrap_s;
    logic [NUM_CH-1:0]    wr_hit_s;
    logic [CNT_WIDTH-1:0] new_div_s;
    logic                 all_zero_s;

    // Per-channel wrap/half-point decode, write targeting and all-zero detection.
    always_comb begin
        all_zero_s = 1'b1;
        new_div_s  = clamp_div(i_cfg_div);
        for (int k = 0; k < NUM_CH; k++) begin
            wrap_s[k]   = (cnt_r[k] == (div_r[k] - CNT_WIDTH'(1)));
            half_s[k]   = div_r[k] >> 1;
            wr_hit_s[k] = i_cfg_we && (i_cfg_ch == CH_W'(k));
            if (cnt_r[k] != {CNT_WIDTH{1'b0}}) begin
                all_zero_s = 1'b0;
            end else begin
                all_zero_s = all_zero_s;
            end
        end
    end

    // Counters, active/pending ratios and registered clock/strobe outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                cnt_r[k]      <= {CNT_WIDTH{1'b0}};
                div_r[k]      <= clamp_div(DEFAULT_DIVS[k*CNT_WIDTH +: CNT_WIDTH]);
                pend_div_r[k] <= {CNT_WIDTH{1'b0}};
            end
            pend_r <= {NUM_CH{1'b0}};
            clk_r  <= {NUM_CH{1'b0}};
            rise_r <= {NUM_CH{1'b0}};
            fall_r <= {NUM_CH{1'b0}};
            sync_r <= 1'b0;
        end else if (i_resync) begin
            // Realign everything; a same-cycle write beats any older pending ratio.
            for (int k = 0; k < NUM_CH; k++) begin
                cnt_r[k] <= {CNT_WIDTH{1'b0}};
                if (wr_hit_s[k]) begin
                    div_r[k] <= new_div_s;
                end else if (pend_r[k]) begin
                    div_r[k] <= pend_div_r[k];
                end else begin
                    div_r[k] <= div_r[k];
                end
            end
            pend_r <= {NUM_CH{1'b0}};
            clk_r  <= {NUM_CH{1'b0}};
            rise_r <= {NUM_CH{1'b0}};
            fall_r <= {NUM_CH{1'b0}};
            sync_r <= 1'b0;
        end else if (i_run) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (wrap_s[k]) begin
                    // Ratio only changes at the period boundary so o_clk never glitches.
                    cnt_r[k] <= {CNT_WIDTH{1'b0}};
                    pend_r[k] <= 1'b0;
                    if (wr_hit_s[k]) begin
                        div_r[k] <= new_div_s;
                    end else if (pend_r[k]) begin
                        div_r[k] <= pend_div_r[k];
                    end else begin
                        div_r[k] <= div_r[k];
                    end
                end else begin
                    cnt_r[k] <= cnt_r[k] + CNT_WIDTH'(1);
                    if (wr_hit_s[k]) begin
                        pend_div_r[k] <= new_div_s;
                        pend_r[k]     <= 1'b1;
                    end else begin
                        pend_r[k] <= pend_r[k];
                    end
                end
                clk_r[k]  <= (cnt_r[k] >= half_s[k]);
                rise_r[k] <= (cnt_r[k] == half_s[k]);
                fall_r[k] <= (cnt_r[k] == {CNT_WIDTH{1'b0}});
            end
            sync_r <= all_zero_s;
        end else begin
            // Frozen: a write is applied at once and restarts its channel low.
            for (int k = 0; k < NUM_CH; k++) begin
                if (wr_hit_s[k]) begin
                    div_r[k]  <= new_div_s;
                    cnt_r[k]  <= {CNT_WIDTH{1'b0}};
                    clk_r[k]  <= 1'b0;
                    pend_r[k] <= 1'b0;
                end else begin
                    cnt_r[k] <= cnt_r[k];
                end
            end
            rise_r <= {NUM_CH{1'b0}};
            fall_r <= {NUM_CH{1'b0}};
            sync_r <= 1'b0;
        end
    end

    assign o_cfg_pending = pend_r;
    assign o_clk         = clk_r;
    assign o_rise_en     = rise_r;
    assign o_fall_en     = fall_r;
    assign o_sync        = sync_r;

endmodule

// File: tb/tb_clock_enable_divider.sv
// Scoreboard bench for clock_enable_divider: stimulus queues cycle-tagged expectations,
// a monitor pops and compares them each cycle.
module tb_clock_enable_divider;

    logic       i_clk = 1'b0;
    logic       i_reset_n, i_run, i_resync, i_cfg_we;
    logic [1:0] i_cfg_ch;
    logic [7:0] i_cfg_div;
    logic [2:0] o_cfg_pending, o_clk, o_rise_en, o_fall_en;
    logic       o_sync;

    always #5 i_clk = ~i_clk;

    clock_enable_divider dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_run(i_run), .i_resync(i_resync),
        .i_cfg_we(i_cfg_we), .i_cfg_ch(i_cfg_ch), .i_cfg_div(i_cfg_div),
        .o_cfg_pending(o_cfg_pending), .o_clk(o_clk), .o_rise_en(o_rise_en),
        .o_fall_en(o_fall_en), .o_sync(o_sync)
    );

    // Observation bus: [2:0] clk, [5:3] rise, [8:6] fall, [9] sync, [12:10] pending.
    logic [12:0] obs;
    assign obs = {o_cfg_pending, o_sync, o_fall_en, o_rise_en, o_clk};

    localparam logic [12:0] ALL    = 13'h1FFF;
    localparam logic [12:0] NONE   = 13'h0000;
    localparam logic [12:0] CLKS   = 13'h0007;
    localparam logic [12:0] CLK0   = 13'h0001;
    localparam logic [12:0] CLK1   = 13'h0002;
    localparam logic [12:0] RISE0  = 13'h0008;
    localparam logic [12:0] FALLS  = 13'h01C0;
    localparam logic [12:0] FALL0  = 13'h0040;
    localparam logic [12:0] SYNC   = 13'h0200;
    localparam logic [12:0] STROBE = 13'h03F8;
    localparam logic [12:0] PEND0  = 13'h0400;
    localparam logic [12:0] PEND1  = 13'h0800;

    typedef struct {
        int          cyc;
        logic [12:0] mask;
        logic [12:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   r0, r2;

    // Default ratios 12/4/2, first 12 run cycles of {ch2,ch1,ch0}.
    logic [2:0] clk_tbl [12] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd0, 3'd4,
                                 3'd3, 3'd7, 3'd1, 3'd5, 3'd3, 3'd7};

    task automatic check(input string nm, input logic [12:0] act,
                         input logic [12:0] m, input logic [12:0] v);
        n_total++;
        if ((act & m) === (v & m)) n_pass++;
        else $display("FAIL %s: got %h, required %h (mask %h)", nm, act & m, v & m, m);
    endtask

    function automatic void want(input int c, input logic [12:0] m,
                                 input logic [12:0] v, input string nm);
        exp_t e;
        e.cyc = c; e.mask = m; e.val = v; e.name = nm;
        sb.push_back(e);
    endfunction

    task automatic go_to(input int n);
        while (cyc < n) @(negedge i_clk);
        if (cyc != n) begin
            n_total++;
            $display("FAIL go_to: at cycle %0d, required %0d", cyc, n);
        end
    endtask

    // Monitor: one sample per cycle, compare every expectation due now.
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            cyc++;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc < cyc) begin
                    n_total++;
                    $display("FAIL %s: expectation for cycle %0d missed, now %0d",
                             sb[i].name, sb[i].cyc, cyc);
                    sb.delete(i);
                end else if (sb[i].cyc == cyc) begin
                    check(sb[i].name, obs, sb[i].mask, sb[i].val);
                    sb.delete(i);
                end
            end
        end
    end

    initial begin
        i_reset_n = 1'b0; i_run = 1'b0; i_resync = 1'b0;
        i_cfg_we = 1'b0; i_cfg_ch = 2'd0; i_cfg_div = 8'd0;
        go_to(2);
        check("reset_state", obs, ALL, NONE);
        i_reset_n = 1'b1;
        i_run     = 1'b1;
        r0 = cyc;

        // Defaults: 12/4/2, sync every 12, rise/fall of ch0.
        for (int t = 1; t <= 25; t++) begin
            if (t <= 24) want(r0 + t, CLKS, {10'd0, clk_tbl[(t-1)%12]}, $sformatf("dflt_clk t=%0d", t));
            want(r0 + t, SYNC, (t == 1 || t == 13 || t == 25) ? SYNC : NONE, $sformatf("dflt_sync t=%0d", t));
            want(r0 + t, RISE0, (t == 7 || t == 19) ? RISE0 : NONE, $sformatf("dflt_rise0 t=%0d", t));
            want(r0 + t, FALL0, (t == 1 || t == 13 || t == 25) ? FALL0 : NONE, $sformatf("dflt_fall0 t=%0d", t));
        end
        // ch0 div=5 written at counter 3; pending until wrap at t=36.
        for (int t = 27; t <= 36; t++)
            want(r0 + t, PEND0, (t >= 28 && t <= 35) ? PEND0 : NONE, $sformatf("div5_pend t=%0d", t));
        for (int t = 37; t <= 46; t++)
            want(r0 + t, CLK0, ((t - 37) % 5 >= 2) ? CLK0 : NONE, $sformatf("div5_clk0 t=%0d", t));
        want(r0 + 37, FALL0, FALL0, "div5_fall0");
        want(r0 + 39, RISE0, RISE0, "div5_rise0");
        for (int t = 26; t <= 57; t++)
            want(r0 + t, SYNC, (t == 37 || t == 57) ? SYNC : NONE, $sformatf("lcm20_sync t=%0d", t));

        go_to(r0 + 27);
        i_cfg_we = 1'b1; i_cfg_ch = 2'd0; i_cfg_div = 8'd5;
        go_to(r0 + 28);
        i_cfg_we = 1'b0;

        // ch1 div=1 then div=0: both clamp to 2.
        for (int t = 57; t <= 60; t++)
            want(r0 + t, PEND1, (t == 58 || t == 59) ? PEND1 : NONE, $sformatf("div1_pend t=%0d", t));
        for (int t = 61; t <= 66; t++)
            want(r0 + t, CLK1, ((t - 61) % 2 == 1) ? CLK1 : NONE, $sformatf("div1_clk1 t=%0d", t));
        want(r0 + 67, PEND1, PEND1, "div0_pend_set");
        want(r0 + 68, PEND1, NONE, "div0_pend_clr");
        for (int t = 69; t <= 74; t++)
            want(r0 + t, CLK1, ((t - 69) % 2 == 1) ? CLK1 : NONE, $sformatf("div0_clk1 t=%0d", t));

        go_to(r0 + 57);
        i_cfg_we = 1'b1; i_cfg_ch = 2'd1; i_cfg_div = 8'd1;
        go_to(r0 + 58);
        i_cfg_we = 1'b0;

        // Pause 5 cycles with ch0 high at count 3.
        want(r0 + 79, CLK0 | RISE0, CLK0 | RISE0, "pre_pause");
        for (int t = 80; t <= 84; t++) begin
            want(r0 + t, CLK0, CLK0, $sformatf("pause_clk0 t=%0d", t));
            want(r0 + t, STROBE, NONE, $sformatf("pause_strobes t=%0d", t));
        end
        want(r0 + 85, CLK0 | FALL0, CLK0, "resume_t85");
        want(r0 + 86, CLK0 | FALL0, CLK0, "resume_t86");
        want(r0 + 87, CLK0 | FALL0, FALL0, "resume_fall0");
        want(r0 + 89, CLK0 | RISE0, CLK0 | RISE0, "resume_rise0");

        go_to(r0 + 66);
        i_cfg_we = 1'b1; i_cfg_ch = 2'd1; i_cfg_div = 8'd0;
        go_to(r0 + 67);
        i_cfg_we = 1'b0;
        go_to(r0 + 79);
        i_run = 1'b0;
        go_to(r0 + 84);
        i_run = 1'b1;

        // Asynchronous reset mid-period while ch0 is high.
        go_to(r0 + 90);
        i_reset_n = 1'b0;
        #1;
        check("async_reset", obs, ALL, NONE);
        go_to(r0 + 93);
        i_reset_n = 1'b1;
        r2 = cyc;

        for (int t = 1; t <= 11; t++)
            want(r2 + t, CLKS, {10'd0, clk_tbl[(t-1)%12]}, $sformatf("rst_dflt_clk t=%0d", t));
        want(r2 + 1, SYNC, SYNC, "rst_sync_first");
        // ch0 div=8 written in the wrap cycle: no pending, next period 8.
        for (int t = 11; t <= 14; t++)
            want(r2 + t, PEND0, NONE, $sformatf("div8_nopend t=%0d", t));
        want(r2 + 12, CLK0, CLK0, "div8_wrapcyc_clk0");
        for (int t = 13; t <= 21; t++) begin
            if (t <= 20) want(r2 + t, CLK0, (t >= 17) ? CLK0 : NONE, $sformatf("div8_clk0 t=%0d", t));
            want(r2 + t, FALL0, (t == 13 || t == 21) ? FALL0 : NONE, $sformatf("div8_fall0 t=%0d", t));
        end
        // ch0 div=6 pending, then resync applies it and realigns all channels.
        want(r2 + 29, PEND0, PEND0, "resync_pend_before");
        want(r2 + 30, ALL, NONE, "resync_cycle");
        want(r2 + 31, 13'h03FF, FALLS | SYNC, "resync_aligned");
        want(r2 + 32, CLKS, 13'h0004, "resync_clk_t32");
        for (int t = 31; t <= 42; t++)
            want(r2 + t, CLK0, ((t - 31) % 6 >= 3) ? CLK0 : NONE, $sformatf("div6_clk0 t=%0d", t));
        for (int t = 32; t <= 43; t++)
            want(r2 + t, SYNC, (t == 43) ? SYNC : NONE, $sformatf("lcm12_sync t=%0d", t));

        go_to(r2 + 11);
        i_cfg_we = 1'b1; i_cfg_ch = 2'd0; i_cfg_div = 8'd8;
        go_to(r2 + 12);
        i_cfg_we = 1'b0;
        go_to(r2 + 28);
        i_cfg_we = 1'b1; i_cfg_ch = 2'd0; i_cfg_div = 8'd6;
        go_to(r2 + 29);
        i_cfg_we = 1'b0; i_resync = 1'b1;
        go_to(r2 + 30);
        i_resync = 1'b0;

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge i_clk);
        while (sb.size() > 0) begin
            n_total++;
            $display("FAIL %s: expectation for cycle %0d never compared", sb[0].name, sb[0].cyc);
            void'(sb.pop_front());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
